// File: rtl/ahb_lite_slv_frontend.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_slv_frontend
// Description : AHB-Lite slave front end. Terminates the AHB address/data
//               phase pipeline and turns each accepted transfer into a
//               single-outstanding dv/hld/err request for the downstream
//               register adapter. Performs size/alignment checking, inserts
//               wait states while the adapter holds, and generates the
//               two-cycle AHB ERROR response.
//
// Configuration macro:
//   AHB_SLV_RDATA_FLOP_EN - when defined, read data is registered and
//                           returned one cycle after the adapter completes
//                           (extra RDRET state). When undefined, hrdata is
//                           driven combinationally from rdata.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   hsel, haddr, hwrite,
//   htrans, hsize       - AHB address phase
//   hwdata              - AHB data-phase write data
//   hready              - bus-wide HREADY in
//   hreadyout, hresp,
//   hrdata              - AHB slave response
//   dv, write, addr,
//   wdata               - request to adapter
//   hld, err, rdata     - adapter response (sampled only while dv=1)
//
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_slv_frontend #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  // AHB-Lite slave side
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  // adapter request side
  output logic                  dv,
  input  logic                  hld,
  input  logic                  err,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  // Doubleword transfers are only legal on a 64-bit data bus.
  localparam logic c_dw64 = (DATA_WIDTH == 64);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_ERR1  = 3'd2,
    ST_ERR2  = 3'd3
`ifdef AHB_SLV_RDATA_FLOP_EN
    ,
    ST_RDRET = 3'd4
`endif
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_take;
  logic                  w_unused;

`ifdef AHB_SLV_RDATA_FLOP_EN
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_rd_cap;
`endif

  // --------------------------------------------------------------------------
  // Address-phase decode
  // --------------------------------------------------------------------------
  // htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY; htrans[0] carries no
  // information this slave needs.
  assign w_accept = hsel && hready && htrans[1];
  assign w_unused = htrans[0];

  // The size/alignment verdict is taken in the address phase and recorded by
  // the state transition (DATA vs ERR1), so hsize itself is not kept.
  assign w_legal  = ((hsize == 3'd2) && (haddr[1:0] == 2'b00)) ||
                    (c_dw64 && (hsize == 3'd3) && (haddr[2:0] == 3'b000));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  // w_take marks the cycles in which a new address phase may be captured:
  // only where this slave is driving hreadyout=1 (IDLE, completing DATA,
  // ERR2, RDRET). While stalled the bus hready is low anyway, so gating
  // here just keeps the capture registers stable against a misbehaving bus.
  always_comb begin
    w_state_nxt = r_state;
    hreadyout   = 1'b1;
    hresp       = 1'b0;
    hrdata      = '0;
    dv          = 1'b0;
    w_take      = 1'b0;
`ifdef AHB_SLV_RDATA_FLOP_EN
    w_rd_cap    = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        w_take = w_accept;
      end

      ST_DATA: begin
        dv = 1'b1;
        if (hld) begin
          hreadyout = 1'b0;
        end else if (err) begin
          // First cycle of the ERROR response; the request is consumed.
          hreadyout   = 1'b0;
          hresp       = 1'b1;
          w_state_nxt = ST_ERR2;
        end else begin
`ifdef AHB_SLV_RDATA_FLOP_EN
          if (!r_write) begin
            // Register the read data and return it next cycle.
            hreadyout   = 1'b0;
            w_rd_cap    = 1'b1;
            w_state_nxt = ST_RDRET;
          end else begin
            w_state_nxt = ST_IDLE;
            w_take      = w_accept;
          end
`else
          if (!r_write) begin
            hrdata = rdata;
          end
          w_state_nxt = ST_IDLE;
          w_take      = w_accept;
`endif
        end
      end

      ST_ERR1: begin
        hreadyout   = 1'b0;
        hresp       = 1'b1;
        w_state_nxt = ST_ERR2;
      end

      ST_ERR2: begin
        hresp       = 1'b1;
        w_state_nxt = ST_IDLE;
        w_take      = w_accept;
      end

`ifdef AHB_SLV_RDATA_FLOP_EN
      ST_RDRET: begin
        hrdata      = r_rdata;
        w_state_nxt = ST_IDLE;
        w_take      = w_accept;
      end
`endif

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A captured address phase overrides the default return to IDLE.
    if (w_take) begin
      w_state_nxt = w_legal ? ST_DATA : ST_ERR1;
    end
  end

  // --------------------------------------------------------------------------
  // Address-phase capture registers
  // --------------------------------------------------------------------------
  // Illegal transfers are captured too so that addr/write always reflect the
  // most recent accepted address phase; dv is never raised for them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_write <= 1'b0;
    end else if (w_take) begin
      r_addr  <= haddr;
      r_write <= hwrite;
    end
  end

`ifdef AHB_SLV_RDATA_FLOP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_cap) begin
      r_rdata <= rdata;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Request outputs
  // --------------------------------------------------------------------------
  // Write data is already in its AHB data phase while dv is high, so it is
  // passed straight through rather than registered.
  assign write = r_write;
  assign addr  = r_addr;
  assign wdata = hwdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_slv_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_slv_frontend
// Description : Directed self-checking bench for ahb_lite_slv_frontend.
//               Expected requests are queued at the address phase and
//               compared when the DUT presents dv && !hld.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_slv_frontend;

  localparam int AW = 32;
  localparam int DW = 64;
`ifdef AHB_SLV_RDATA_FLOP_EN
  localparam bit RDFLOP = 1'b1;
`else
  localparam bit RDFLOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;
  logic          dv;
  logic          hld;
  logic          err;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          hready_lo;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  req_t sb[$];
  int   total  = 0;
  int   bad    = 0;
  int   dv_cnt = 0;

  always #5 clk = ~clk;

  // Single-slave bus: HREADY follows this slave unless the bench stalls it.
  assign hready = hready_lo ? 1'b0 : hreadyout;

  ahb_lite_slv_frontend #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .dv(dv), .hld(hld), .err(err), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to the sampling point (falling edge) and run the scoreboard.
  task automatic settle();
    req_t e;
    #4;
    if (dv === 1'b1 && hld === 1'b0) begin
      dv_cnt++;
      chk("sb_pending", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_write", 64'(write), 64'(e.w));
        chk("sb_addr", 64'(addr), 64'(e.a));
        if (e.w) chk("sb_wdata", wdata, e.d);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic aphase(input logic w, input logic [AW-1:0] a, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = 2'd2;
    hwrite = w;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'd0;
  endtask

  task automatic resp(input string tag, input logic ro, input logic rs, input logic d);
    chk({tag, "_hreadyout"}, 64'(hreadyout), 64'(ro));
    chk({tag, "_hresp"}, 64'(hresp), 64'(rs));
    chk({tag, "_dv"}, 64'(dv), 64'(d));
  endtask

  initial begin
    int base;
    rst = 1'b1; hsel = 1'b0; haddr = '0; hwrite = 1'b0; htrans = 2'd0;
    hsize = 3'd0; hwdata = '0; hld = 1'b0; err = 1'b0; rdata = '0;
    hready_lo = 1'b0;

    // ---------------- reset state ----------------
    adv(); adv();
    settle();
    resp("rst", 1'b1, 1'b0, 1'b0);
    chk("rst_hrdata", hrdata, 64'd0);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    adv();
    rst = 1'b0;

    // ---------------- zero-wait doubleword write ----------------
    aphase(1'b1, 32'h1000, 3'd3);
    sb.push_back('{w: 1'b1, a: 32'h1000, d: 64'hDEADBEEF_CAFEF00D});
    settle();
    resp("wr_aph", 1'b1, 1'b0, 1'b0);
    adv();
    bus_idle();
    hwdata = 64'hDEADBEEF_CAFEF00D;
    settle();
    resp("wr_dph", 1'b1, 1'b0, 1'b1);
    adv();
    settle();
    resp("wr_after", 1'b1, 1'b0, 1'b0);
    chk("wr_addr_hold", 64'(addr), 64'h1000);
    chk("wr_dv_cnt", 64'(dv_cnt), 64'd1);

    // ---------------- read with three held cycles ----------------
    adv();
    aphase(1'b0, 32'h2008, 3'd3);
    sb.push_back('{w: 1'b0, a: 32'h2008, d: 64'd0});
    settle();
    adv();
    bus_idle();
    hld = 1'b1;
    rdata = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      settle();
      resp("rd_hold", 1'b0, 1'b0, 1'b1);
      chk("rd_hold_addr", 64'(addr), 64'h2008);
      chk("rd_hold_hrdata", hrdata, 64'd0);
      adv();
    end
    hld = 1'b0;
    settle();
    if (RDFLOP) begin
      resp("rd_cap", 1'b0, 1'b0, 1'b1);
      adv();
      rdata = 64'hFFFF;
      settle();
      resp("rd_ret", 1'b1, 1'b0, 1'b0);
    end else begin
      resp("rd_done", 1'b1, 1'b0, 1'b1);
    end
    chk("rd_hrdata", hrdata, 64'h1234);
    adv();
    rdata = '0;
    settle();
    chk("rd_hrdata_after", hrdata, 64'd0);
    chk("rd_dv_cnt", 64'(dv_cnt), 64'd2);

    // ---------------- illegal transfers: halfword, misaligned dword ----------------
    for (int k = 0; k < 2; k++) begin
      adv();
      if (k == 0) aphase(1'b1, 32'h0010, 3'd1);
      else        aphase(1'b0, 32'h2004, 3'd3);
      settle();
      adv();
      bus_idle();
      settle();
      resp("ill_err1", 1'b0, 1'b1, 1'b0);
      adv();
      settle();
      resp("ill_err2", 1'b1, 1'b1, 1'b0);
      adv();
      settle();
      resp("ill_idle", 1'b1, 1'b0, 1'b0);
    end
    chk("ill_dv_cnt", 64'(dv_cnt), 64'd2);

    // ---------------- read completing with adapter error ----------------
    adv();
    aphase(1'b0, 32'h3000, 3'd2);
    sb.push_back('{w: 1'b0, a: 32'h3000, d: 64'd0});
    settle();
    adv();
    bus_idle();
    err = 1'b1;
    rdata = 64'h5555;
    settle();
    resp("err_c1", 1'b0, 1'b1, 1'b1);
    chk("err_c1_hrdata", hrdata, 64'd0);
    adv();
    settle();
    resp("err_c2", 1'b1, 1'b1, 1'b0);
    adv();
    err = 1'b0;
    settle();
    resp("err_idle", 1'b1, 1'b0, 1'b0);
    chk("err_dv_cnt", 64'(dv_cnt), 64'd3);

    // ---------------- four back-to-back writes ----------------
    adv();
    base = dv_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        aphase(1'b1, 32'(i * 8), 3'd3);
        sb.push_back('{w: 1'b1, a: 32'(i * 8), d: 64'hA0 + 64'(i)});
      end else begin
        bus_idle();
      end
      if (i > 0) hwdata = 64'hA0 + 64'(i - 1);
      settle();
      if (i > 0) resp("b2b", 1'b1, 1'b0, 1'b1);
      adv();
    end
    // BUSY, then a NONSEQ while HREADY is held low: neither is a transfer.
    hsel = 1'b1; htrans = 2'd1; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd3;
    settle();
    resp("busy_aph", 1'b1, 1'b0, 1'b0);
    adv();
    htrans = 2'd2;
    hready_lo = 1'b1;
    settle();
    resp("busy_dph", 1'b1, 1'b0, 1'b0);
    adv();
    bus_idle();
    hready_lo = 1'b0;
    settle();
    resp("nrdy_dph", 1'b1, 1'b0, 1'b0);
    chk("b2b_dv_cnt", 64'(dv_cnt - base), 64'd4);

    // ---------------- reset while held in data phase ----------------
    adv();
    aphase(1'b0, 32'h4000, 3'd2);
    sb.push_back('{w: 1'b0, a: 32'h4000, d: 64'd0});
    settle();
    adv();
    bus_idle();
    hld = 1'b1;
    settle();
    resp("rstmid_hold", 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    resp("rstmid_now", 1'b1, 1'b0, 1'b0);
    sb.delete();
    adv();
    rst = 1'b0;
    hld = 1'b0;
    aphase(1'b1, 32'h5000, 3'd2);
    sb.push_back('{w: 1'b1, a: 32'h5000, d: 64'h77});
    settle();
    adv();
    bus_idle();
    hwdata = 64'h77;
    settle();
    resp("post_rst", 1'b1, 1'b0, 1'b1);
    adv();
    settle();
    resp("post_rst_idle", 1'b1, 1'b0, 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("final_dv_cnt", 64'(dv_cnt), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed sequence is short; a hang is a failure.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
